// File: rtl/aes_ctrl_pkg.sv
// Shared encodings for the AES-128 inverse-cipher sequencer: datapath op codes, FSM states
// and the registered control-output bundle.
package aes_ctrl_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [2:0] {
        OP_NONE     = 3'd0,
        OP_LOAD     = 3'd1,
        OP_ADDKEY   = 3'd2,
        OP_INVSHIFT = 3'd3,
        OP_INVSUB   = 3'd4,
        OP_INVMIX   = 3'd5
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_KEYEXP  = 4'd2,
        ST_ADDINIT = 4'd3,
        ST_ISHIFT  = 4'd4,
        ST_ISUB    = 4'd5,
        ST_ADDKEY  = 4'd6,
        ST_IMIX    = 4'd7,
        ST_DONE    = 4'd8
    } state_e;

    typedef struct packed {
        logic       done;
        logic       busy;
        logic       keyexp_go;
        op_e        op_sel;
        logic       state_we;
        logic [3:0] rk_idx;
        logic [1:0] mix_col;
    } ctrl_out_t;

endpackage

// File: rtl/aes_inv_cipher_ctrl.sv
// AES-128 inverse-cipher sequencer; done rises 1+K+1+9*(6+S)+(2+S) cycles after the sampled start edge.
// No backpressure: start is a level qualified on its rising edge, and is ignored while busy.
module aes_inv_cipher_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int KEYEXP_CYCLES = 10,
    parameter int SUB_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic       keyexp_go,
    output logic [2:0] op_sel,
    output logic       state_we,
    output logic [3:0] rk_idx,
    output logic [1:0] mix_col
);

    localparam logic [3:0] KEYEXP_LAST = 4'(KEYEXP_CYCLES - 1);
    localparam logic [3:0] SUB_LAST    = 4'(SUB_CYCLES - 1);
    localparam logic [3:0] NR          = 4'(AES_NR);

    state_e    state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] rnd, rnd_nxt;
    logic       start_d;
    logic       start_rise;
    logic       dwell_end;
    ctrl_out_t  out_q, out_nxt;

    assign start_rise = start & ~start_d;
    assign dwell_end  = (cnt == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rnd     <= '0;
            start_d <= 1'b0;
            out_q   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rnd     <= rnd_nxt;
            start_d <= start;
            out_q   <= out_nxt;
        end
    end

    // One down-counter is reloaded on every state entry and times the multi-cycle dwells.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start_rise) state_nxt = ST_LOAD;
            ST_LOAD:    state_nxt = ST_KEYEXP;
            ST_KEYEXP:  if (dwell_end) state_nxt = ST_ADDINIT;
            ST_ADDINIT: state_nxt = ST_ISHIFT;
            ST_ISHIFT:  state_nxt = ST_ISUB;
            ST_ISUB:    if (dwell_end) state_nxt = ST_ADDKEY;
            ST_ADDKEY:  state_nxt = (rnd < NR) ? ST_IMIX : ST_DONE;
            ST_IMIX:    if (dwell_end) state_nxt = ST_ISHIFT;
            ST_DONE:    if (!start) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase

        cnt_nxt = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
        if (state_nxt != state) begin
            case (state_nxt)
                ST_KEYEXP: cnt_nxt = KEYEXP_LAST;
                ST_ISUB:   cnt_nxt = SUB_LAST;
                ST_IMIX:   cnt_nxt = 4'd3;
                default:   cnt_nxt = 4'd0;
            endcase
        end

        rnd_nxt = rnd;
        if (state_nxt == ST_ADDINIT)
            rnd_nxt = 4'd1;
        else if (state == ST_IMIX && state_nxt == ST_ISHIFT)
            rnd_nxt = rnd + 4'd1;
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        out_nxt        = '0;
        out_nxt.rk_idx = out_q.rk_idx;
        out_nxt.busy   = !(state_nxt inside {ST_IDLE, ST_DONE});
        case (state_nxt)
            ST_LOAD: begin
                out_nxt.op_sel    = OP_LOAD;
                out_nxt.state_we  = 1'b1;
                out_nxt.keyexp_go = 1'b1;
            end
            ST_ADDINIT: begin
                out_nxt.op_sel   = OP_ADDKEY;
                out_nxt.rk_idx   = NR;
                out_nxt.state_we = 1'b1;
            end
            ST_ISHIFT: begin
                out_nxt.op_sel   = OP_INVSHIFT;
                out_nxt.state_we = 1'b1;
            end
            ST_ISUB: begin
                out_nxt.op_sel   = OP_INVSUB;
                out_nxt.state_we = (cnt_nxt == 4'd0);
            end
            ST_ADDKEY: begin
                out_nxt.op_sel   = OP_ADDKEY;
                out_nxt.rk_idx   = NR - rnd_nxt;
                out_nxt.state_we = 1'b1;
            end
            ST_IMIX: begin
                out_nxt.op_sel   = OP_INVMIX;
                out_nxt.state_we = 1'b1;
                out_nxt.mix_col  = 2'd3 - cnt_nxt[1:0];
            end
            ST_DONE: out_nxt.done = 1'b1;
            default: ;
        endcase
    end

    assign done      = out_q.done;
    assign busy      = out_q.busy;
    assign keyexp_go = out_q.keyexp_go;
    assign op_sel    = out_q.op_sel;
    assign state_we  = out_q.state_we;
    assign rk_idx    = out_q.rk_idx;
    assign mix_col   = out_q.mix_col;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: a default instance and a KEYEXP=4/SUB=2 instance, each driving
// a behavioural AES datapath so the sequence must decrypt the FIPS-197 vector.
module tb_aes_inv_cipher_ctrl;
    import aes_ctrl_pkg::*;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, start_b;
    logic       done, busy, keyexp_go, state_we;
    logic [2:0] op_sel;
    logic [3:0] rk_idx;
    logic [1:0] mix_col;
    logic       done_b, busy_b, keyexp_go_b, state_we_b;
    logic [2:0] op_sel_b;
    logic [3:0] rk_idx_b;
    logic [1:0] mix_col_b;

    aes_inv_cipher_ctrl #(.KEYEXP_CYCLES(10), .SUB_CYCLES(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .done(done), .busy(busy),
        .keyexp_go(keyexp_go), .op_sel(op_sel), .state_we(state_we), .rk_idx(rk_idx), .mix_col(mix_col)
    );

    aes_inv_cipher_ctrl #(.KEYEXP_CYCLES(4), .SUB_CYCLES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .done(done_b), .busy(busy_b),
        .keyexp_go(keyexp_go_b), .op_sel(op_sel_b), .state_we(state_we_b), .rk_idx(rk_idx_b), .mix_col(mix_col_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           exp_lat_q[$];
    logic [127:0] exp_pt_q[$];

    logic [7:0]   sbox[256];
    logic [7:0]   isbox[256];
    logic [127:0] rks[16];
    logic [127:0] st_a, st_b;

    int         kg_cnt = 0, mix_cnt = 0, mix_after0 = 0, mix_bad = 0;
    logic [1:0] mix_exp = 2'd0;
    bit         seen_rk0 = 0;
    logic [3:0] rk_q[$];
    int         sub_pos = 0, sub_bad = 0, sub_seen = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] dp_step(input logic [127:0] s, input logic [2:0] op,
                                             input logic [3:0] rk, input logic [1:0] col);
        logic [127:0] n;
        logic [7:0]   a[4];
        n = s;
        case (op)
            OP_LOAD:     n = CT;
            OP_ADDKEY:   n = s ^ rks[rk];
            OP_INVSHIFT:
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        n[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            OP_INVSUB:
                for (int i = 0; i < 16; i++) n[127-8*i -: 8] = isbox[s[127-8*i -: 8]];
            OP_INVMIX: begin
                for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*col+k) -: 8];
                n[127-8*(4*col+0) -: 8] = gmul(a[0],8'h0e) ^ gmul(a[1],8'h0b) ^ gmul(a[2],8'h0d) ^ gmul(a[3],8'h09);
                n[127-8*(4*col+1) -: 8] = gmul(a[0],8'h09) ^ gmul(a[1],8'h0e) ^ gmul(a[2],8'h0b) ^ gmul(a[3],8'h0d);
                n[127-8*(4*col+2) -: 8] = gmul(a[0],8'h0d) ^ gmul(a[1],8'h09) ^ gmul(a[2],8'h0e) ^ gmul(a[3],8'h0b);
                n[127-8*(4*col+3) -: 8] = gmul(a[0],8'h0b) ^ gmul(a[1],8'h0d) ^ gmul(a[2],8'h09) ^ gmul(a[3],8'h0e);
            end
            default: n = s;
        endcase
        return n;
    endfunction

    // Datapath models and trace collectors, sampled mid-cycle.
    always @(negedge clk) begin
        if (keyexp_go) kg_cnt++;
        if (op_sel == OP_ADDKEY) begin
            rk_q.push_back(rk_idx);
            if (rk_idx == 4'd0) seen_rk0 = 1;
        end
        if (op_sel == OP_INVMIX) begin
            mix_cnt++;
            if (seen_rk0) mix_after0++;
            if (mix_col != mix_exp) mix_bad++;
            mix_exp = mix_exp + 2'd1;
        end
        if (state_we) st_a = dp_step(st_a, op_sel, rk_idx, mix_col);
    end

    always @(negedge clk) begin
        if (op_sel_b == OP_INVSUB) begin
            sub_pos++;
            sub_seen++;
            if (state_we_b !== (sub_pos == 2)) sub_bad++;
        end else begin
            sub_pos = 0;
        end
        if (state_we_b) st_b = dp_step(st_b, op_sel_b, rk_idx_b, mix_col_b);
    end

    task automatic run(input bit b, input bit hold, input bit toggle, input int budget);
        int e0, lat;
        bit got, busy_ok, d, bz;
        @(negedge clk);
        if (b) start_b = 1'b1; else start = 1'b1;
        e0 = cyc + 1;
        exp_lat_q.push_back(b ? 82 : 78);
        exp_pt_q.push_back(PT);
        got = 0; busy_ok = 1; lat = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (i == 0)
                chk(b ? "b_load_cycle1" : "load_cycle1",
                    b ? {op_sel_b, keyexp_go_b} : {op_sel, keyexp_go}, {OP_LOAD, 1'b1});
            d  = b ? done_b : done;
            bz = b ? busy_b : busy;
            if (d) begin
                got = 1;
                lat = cyc - e0;
            end else if (!bz) busy_ok = 0;
            if (!hold) begin
                if (b) start_b = 1'b0;
                else start = toggle && i >= 10 && i < 16 && (i % 2 == 0);
            end
        end
        chk("done_seen", got, 1);
        chk("busy_during_run", busy_ok, 1);
        chk("done_latency", lat, exp_lat_q.pop_front());
        chk("plaintext", b ? st_b : st_a, exp_pt_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  inv, s, rc;
        logic [31:0] w[44];
        logic [31:0] t;
        int          kg0;
        bit          stay_ok;

        reset_n = 1'b0; start = 1'b0; start_b = 1'b0;
        st_a = '0; st_b = '0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 16; k++) rks[k] = '0;
        for (int k = 0; k < 11; k++) rks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_outputs", {done, busy, keyexp_go, op_sel, state_we, rk_idx, mix_col}, 13'd0);
        chk("reset_outputs_b", {done_b, busy_b, keyexp_go_b, op_sel_b, state_we_b, rk_idx_b, mix_col_b}, 13'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single start pulse with full op trace
        rk_q.delete(); seen_rk0 = 0; mix_cnt = 0; mix_after0 = 0; mix_bad = 0; mix_exp = 2'd0; kg0 = kg_cnt;
        run(0, 0, 0, 150);
        @(negedge clk);
        chk("done_clears_to_idle", {done, busy, op_sel}, 5'd0);
        chk("rk_count", rk_q.size(), 11);
        for (int i = 0; i < rk_q.size() && i < 11; i++) chk("rk_seq", rk_q[i], 10 - i);
        chk("invmix_cycles", mix_cnt, 36);
        chk("invmix_col_order_errors", mix_bad, 0);
        chk("invmix_after_rk0", mix_after0, 0);
        chk("keyexp_pulses", kg_cnt - kg0, 1);

        // start held high: one run, done held until start drops
        kg0 = kg_cnt;
        run(0, 1, 0, 150);
        stay_ok = 1;
        for (int i = 0; i < 122; i++) begin
            @(negedge clk);
            if (!done || busy) stay_ok = 0;
        end
        chk("done_held", stay_ok, 1);
        chk("single_run_while_held", kg_cnt - kg0, 1);
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_drop", {done, busy}, 2'b00);

        // Async reset mid-sequence
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {done, busy, keyexp_go, op_sel, state_we, rk_idx, mix_col}, 13'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Full run after reset, with start toggled while busy
        kg0 = kg_cnt;
        run(0, 0, 1, 150);
        chk("toggle_no_restart", kg_cnt - kg0, 1);

        // Non-default timing instance
        repeat (2) @(negedge clk);
        sub_bad = 0; sub_seen = 0;
        run(1, 0, 0, 150);
        chk("b_sub_we_pattern_errors", sub_bad, 0);
        chk("b_sub_cycles", sub_seen, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
